// File: rtl/sb_pkg.sv
// Shared definitions for the sideband receive path.
//
// Contents:
//   DLE, ETX, STX_MASK/STX_VAL - framing byte values
//   CRC_POLY, CRC_INIT         - CRC-16 parameters (MSB-first, no reflection, no final XOR)
//   sb_state_e                 - deframer FSM states
//   sb_uart_state_e            - symbol deserializer states
//   crc16_byte()               - fold one byte into a running CRC-16
package sb_pkg;

   localparam logic [7:0]  DLE      = 8'hFE;
   localparam logic [7:0]  ETX      = 8'h40;
   localparam logic [7:0]  STX_MASK = 8'h1F;
   localparam logic [7:0]  STX_VAL  = 8'h05;
   localparam logic [15:0] CRC_POLY = 16'h8005;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      StHunt,
      StGotDle,
      StPayload,
      StPayDle
   } sb_state_e;

   typedef enum logic [1:0] {
      UartIdle,
      UartData,
      UartStop,
      UartWaitHigh
   } sb_uart_state_e;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                              input logic [7:0]  data);
      logic [15:0] crc;
      crc = crc_in ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         crc = crc[15] ? ((crc << 1) ^ CRC_POLY) : (crc << 1);
      end
      return crc;
   endfunction

endpackage

// File: rtl/sb_uart_rx.sv
// Sideband symbol deserializer: one sample of sbrx per sb_clk, recovers 10-bit
// UART symbols (start 0, 8 data bits LSB first, stop 1).
//
// Ports:
//   sb_clk      in   sideband clock, one bit-time per cycle
//   rst         in   asynchronous active-low reset
//   enable      in   low forces the deserializer to idle and drops pending strobes
//   sbrx        in   serial input, idles high
//   byte_data   out  last received data byte, stable while byte_valid is high
//   byte_valid  out  registered strobe, one cycle, for a symbol with a good stop bit
//   stop_err    out  registered strobe, one cycle, for a symbol whose stop bit was 0
module sb_uart_rx
   import sb_pkg::*;
(
   input  logic       sb_clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       sbrx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       stop_err
);

   sb_uart_state_e state_q, state_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           byte_valid_q, byte_valid_d;
   logic           stop_err_q, stop_err_d;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      stop_err_d   = 1'b0;

      unique case (state_q)
         UartIdle: begin
            if (!sbrx) begin
               state_d   = UartData;
               bit_cnt_d = 3'd0;
            end
         end
         UartData: begin
            shift_d   = {sbrx, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               state_d = UartStop;
            end
         end
         UartStop: begin
            if (sbrx) begin
               byte_valid_d = 1'b1;
               state_d      = UartIdle;
            end else begin
               stop_err_d = 1'b1;
               state_d    = UartWaitHigh;
            end
         end
         UartWaitHigh: begin
            // A broken symbol may leave the line low; only a high sample re-arms start detection.
            if (sbrx) begin
               state_d = UartIdle;
            end
         end
      endcase

      if (!enable) begin
         state_d      = UartIdle;
         byte_valid_d = 1'b0;
         stop_err_d   = 1'b0;
      end
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q      <= UartIdle;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         byte_valid_q <= 1'b0;
         stop_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         stop_err_q   <= stop_err_d;
      end
   end

   assign byte_data  = shift_q;
   assign byte_valid = byte_valid_q;
   assign stop_err   = stop_err_q;

endmodule

// File: rtl/sb_rx_deframer.sv
// Sideband receive deframer: finds DLE/STX ... DLE/ETX frames in the symbol
// stream, removes DLE stuffing, strips the two trailing CRC bytes through a
// two-byte delay line and reports per-frame completion status.
//
// Build option: define SB_RX_CRC_EN to build the CRC-16 register and compare
// it against the received CRC; without it rx_crc_err is tied low while the
// trailing bytes are still stripped and the short-frame check is kept.
//
// Ports:
//   sb_clk        in   sideband clock
//   rst           in   asynchronous active-low reset
//   sbrx          in   serial sideband input, idles high
//   enable        in   receiver enable; low forces idle/HUNT without status
//   rx_data       out  payload byte (0 when rx_valid is low)
//   rx_valid      out  one cycle per payload byte
//   rx_sop        out  first payload byte of a frame
//   rx_rsp        out  response flag from STX bit 5, held until the next STX
//   rx_done       out  one-cycle pulse, frame ended with DLE ETX
//   rx_crc_err    out  with rx_done, CRC mismatch
//   rx_frame_err  out  one-cycle pulse on abort (stop bit, bad DLE pair, short frame)
//   rx_ovf        out  one-cycle pulse on abort for payload beyond MAX_PAYLOAD
module sb_rx_deframer
   import sb_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = 64
) (
   input  logic       sb_clk,
   input  logic       rst,
   input  logic       sbrx,
   input  logic       enable,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_sop,
   output logic       rx_rsp,
   output logic       rx_done,
   output logic       rx_crc_err,
   output logic       rx_frame_err,
   output logic       rx_ovf
);

   localparam int unsigned      CntW   = $clog2(MAX_PAYLOAD + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_PAYLOAD);

   logic [7:0] byte_data;
   logic       byte_valid;
   logic       stop_err;

   sb_uart_rx u_uart_rx (
      .sb_clk     (sb_clk),
      .rst        (rst),
      .enable     (enable),
      .sbrx       (sbrx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .stop_err   (stop_err)
   );

   sb_state_e       state_q, state_d;
   logic [7:0]      dl_old_q, dl_old_d;
   logic [7:0]      dl_new_q, dl_new_d;
   logic [1:0]      dl_cnt_q, dl_cnt_d;
   logic [CntW-1:0] pay_cnt_q, pay_cnt_d;

   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       sop_q, sop_d;
   logic       rsp_q, rsp_d;
   logic       done_q, done_d;
   logic       frame_err_q, frame_err_d;
   logic       ovf_q, ovf_d;

   logic       push;     // byte enters the delay line
   logic       stx_hit;  // STX accepted this cycle
   logic       emit;     // oldest delay-line byte leaves as payload

   always_comb begin
      state_d     = state_q;
      dl_old_d    = dl_old_q;
      dl_new_d    = dl_new_q;
      dl_cnt_d    = dl_cnt_q;
      pay_cnt_d   = pay_cnt_q;
      data_d      = 8'h00;
      valid_d     = 1'b0;
      sop_d       = 1'b0;
      rsp_d       = rsp_q;
      done_d      = 1'b0;
      frame_err_d = 1'b0;
      ovf_d       = 1'b0;
      push        = 1'b0;
      stx_hit     = 1'b0;
      emit        = 1'b0;

      if (!enable) begin
         state_d   = StHunt;
         dl_cnt_d  = 2'd0;
         pay_cnt_d = '0;
         rsp_d     = 1'b0;
      end else if (stop_err) begin
         frame_err_d = 1'b1;
         state_d     = StHunt;
      end else if (byte_valid) begin
         unique case (state_q)
            StHunt: begin
               if (byte_data == DLE) begin
                  state_d = StGotDle;
               end
            end
            StGotDle: begin
               if ((byte_data & STX_MASK) == STX_VAL) begin
                  stx_hit   = 1'b1;
                  rsp_d     = byte_data[5];
                  dl_cnt_d  = 2'd0;
                  pay_cnt_d = '0;
                  state_d   = StPayload;
               end else if (byte_data != DLE) begin
                  state_d = StHunt;
               end
            end
            StPayload: begin
               if (byte_data == DLE) begin
                  state_d = StPayDle;
               end else begin
                  push = 1'b1;
               end
            end
            StPayDle: begin
               if (byte_data == DLE) begin
                  push    = 1'b1;
                  state_d = StPayload;
               end else if (byte_data == ETX) begin
                  state_d = StHunt;
                  // The delay line must hold both CRC bytes for a valid frame end.
                  if (dl_cnt_q != 2'd2) begin
                     frame_err_d = 1'b1;
                  end else begin
                     done_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StHunt;
               end
            end
         endcase
      end

      if (push) begin
         if (dl_cnt_q == 2'd2) begin
            if (pay_cnt_q == MaxCnt) begin
               ovf_d   = 1'b1;
               state_d = StHunt;
            end else begin
               emit      = 1'b1;
               valid_d   = 1'b1;
               data_d    = dl_old_q;
               sop_d     = (pay_cnt_q == '0);
               pay_cnt_d = pay_cnt_q + 1'b1;
            end
         end else begin
            dl_cnt_d = dl_cnt_q + 2'd1;
         end
         dl_old_d = dl_new_q;
         dl_new_d = byte_data;
      end
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StHunt;
         dl_old_q    <= 8'h00;
         dl_new_q    <= 8'h00;
         dl_cnt_q    <= 2'd0;
         pay_cnt_q   <= '0;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         sop_q       <= 1'b0;
         rsp_q       <= 1'b0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dl_old_q    <= dl_old_d;
         dl_new_q    <= dl_new_d;
         dl_cnt_q    <= dl_cnt_d;
         pay_cnt_q   <= pay_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         sop_q       <= sop_d;
         rsp_q       <= rsp_d;
         done_q      <= done_d;
         frame_err_q <= frame_err_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef SB_RX_CRC_EN
   logic [15:0] crc_q, crc_d;
   logic        crc_err_q, crc_err_d;

   // Running CRC covers the STX byte and every emitted payload byte.
   always_comb begin
      crc_d = crc_q;
      if (!enable) begin
         crc_d = CRC_INIT;
      end else if (stx_hit) begin
         crc_d = crc16_byte(CRC_INIT, byte_data);
      end else if (emit) begin
         crc_d = crc16_byte(crc_q, dl_old_q);
      end
   end

   // Received CRC is low byte first: the older held byte is the low half.
   assign crc_err_d = done_d && ({dl_new_q, dl_old_q} != crc_q);

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         crc_q     <= CRC_INIT;
         crc_err_q <= 1'b0;
      end else begin
         crc_q     <= crc_d;
         crc_err_q <= crc_err_d;
      end
   end

   assign rx_crc_err = crc_err_q;
`else
   logic unused_crc_ctl;
   assign unused_crc_ctl = stx_hit ^ emit;
   assign rx_crc_err     = 1'b0;
`endif

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_sop       = sop_q;
   assign rx_rsp       = rsp_q;
   assign rx_done      = done_q;
   assign rx_frame_err = frame_err_q;
   assign rx_ovf       = ovf_q;

endmodule
